// File: rtl/segway_auth_pkg.sv
// Shared types and constants for the Segway power-authorization receiver.
package segway_auth_pkg;
  typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;
  typedef enum {IDLE, RECV} rx_state_t;

  localparam logic [7:0] CMD_GO        = 8'h47;
  localparam logic [7:0] CMD_STOP      = 8'h53;
  localparam int         BAUD_DIV_DFLT = 2604;
endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: RX synchronizer, baud/bit counters, right shifter.
// Stop-bit checking is enabled by SEG_AUTH_FRMERR_EN.
module uart_rx_core
  import segway_auth_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV >> 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

  rx_state_t     state;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          start_edge, stop_ok;

  assign start_edge = rx_prev & ~rx_sync;

`ifdef SEG_AUTH_FRMERR_EN
  logic stop_tick;
  assign stop_tick = (state == RECV) && (baud_cnt == '0) && (bit_cnt == 4'd9);
  assign stop_ok   = rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         frm_err <= 1'b0;
    else if (stop_tick) frm_err <= ~rx_sync;
  end
`else
  assign stop_ok = 1'b1;
  assign frm_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (clr_rdy) rdy <= 1'b0;
      case (state)
        IDLE: if (start_edge) begin
          state    <= RECV;
          baud_cnt <= HALF;
          bit_cnt  <= '0;
          rdy      <= 1'b0;
        end
        RECV: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            baud_cnt <= FULL;
            bit_cnt  <= bit_cnt + 1'b1;
            // sample 0 = start bit, 1..8 = data LSB first, 9 = stop bit
            if (bit_cnt == 4'd0) begin
              if (rx_sync) state <= IDLE;
            end else if (bit_cnt < 4'd9) begin
              shift <= {rx_sync, shift[7:1]};
            end else begin
              state <= IDLE;
              if (stop_ok) begin
                rx_data <= shift;
                rdy     <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/segway_auth_rx.sv
// UART command receiver plus power-authorization FSM for the Segway.
// Optional stop-bit error reporting: define SEG_AUTH_FRMERR_EN.
module segway_auth_rx
  import segway_auth_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err
);
  auth_state_t state, state_nxt;
  logic        consume;

  // The byte is consumed on the edge after rx_rdy rises, which also clears rx_rdy.
  assign consume = rx_rdy;

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (consume),
    .rx_data (rx_data),
    .rdy     (rx_rdy),
    .frm_err (frm_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= OFF;
      pwr_up <= 1'b0;
    end else begin
      state  <= state_nxt;
      pwr_up <= (state_nxt != OFF);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OFF:  if (consume && rx_data == CMD_GO) state_nxt = PWR1;
      PWR1: if (consume && rx_data == CMD_STOP) state_nxt = rider_off ? OFF : PWR2;
      PWR2: begin
        // waiting for the rider to step off; a fresh GO cancels the power-down
        if (consume && rx_data == CMD_GO) state_nxt = PWR1;
        else if (rider_off)               state_nxt = OFF;
      end
      default: state_nxt = OFF;
    endcase
  end
endmodule
